serial_link: RTL and testbench

//  Parametrised host-link engine between the AVR serial interface, the nonce module and the result block RAM.

---
 rtl/serial_link.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_serial_link.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link.sv
// serial_link - host-link engine between the AVR serial port, the nonce module
// and the result block RAM.
//
// RX side parses framed host commands:
//   HEADER, 8'h01 (LOAD), NONCE_BYTES payload bytes [, XOR checksum]
//   HEADER, 8'h02 (REPORT)
// LOAD bytes are streamed straight into the nonce module; REPORT queues one
// result frame on the TX side (further REPORTs coalesce while one is pending).
//
// TX side emits the result frame:
//   HEADER, status snapshot, RESULT_BYTES from RAM [, XOR of all preceding bytes]
// and then pulses reset_best_nonce_module_o.
//
// Optional feature macro: SERIAL_CHECKSUM_EN
//   defined   : RX checksum byte is verified, TX checksum byte is appended.
//   undefined : no checksum byte in either direction, no checksum errors.

module serial_link #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         NONCE_BYTES    = 128,
  parameter int         RESULT_BYTES   = 32,
  parameter int         RAM_AW         = 5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [RAM_AW-1:0] ram_address_o,
  input  logic [7:0]        ram_data_i,
  output logic [7:0]        tx_data_o,
  output logic              new_tx_data_o,
  input  logic              tx_busy_i,
  input  logic [7:0]        rx_data_i,
  input  logic              new_rx_data_i,
  input  logic [7:0]        status_i,
  output logic [7:0]        rx_byte_o,
  output logic              shift_in_o,
  output logic              ready_o,
  output logic              reset_best_nonce_module_o,
  output logic              rx_error_o
);

  // Command codes carried in the byte after HEADER.
  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_REPORT = 8'h02;

  // Timeout counter counts idle cycles since the last received byte.
  localparam int              TO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] LP_TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      LP_NONCE_LAST = 8'(NONCE_BYTES - 1);
  localparam logic [RAM_AW-1:0] LP_ADDR_LAST = RAM_AW'(RESULT_BYTES - 1);

  typedef enum logic [1:0] {
    R_HDR,
    R_CMD,
    R_DATA,
    R_SUM
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_HDR,
    T_STAT,
    T_DATA,
    T_SUM,
    T_DONE
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // RX state
  // ---------------------------------------------------------------------------
  rx_state_t         r_rx_state;
  logic [7:0]        r_rx_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [7:0]        r_rx_byte;
  logic              r_shift_in;
  logic              r_ready;
  logic              r_rx_err;
`ifdef SERIAL_CHECKSUM_EN
  logic [7:0]        r_rx_sum;
`endif

  // ---------------------------------------------------------------------------
  // TX state
  // ---------------------------------------------------------------------------
  tx_state_t         r_tx_state;
  logic              r_pending;
  logic [7:0]        r_status;
  logic [RAM_AW-1:0] r_addr;
  logic [7:0]        r_tx_data;
  logic              r_new_tx;
  logic              r_tx_hold;
  logic              r_rbest;
`ifdef SERIAL_CHECKSUM_EN
  logic [7:0]        r_tx_sum;
`endif

  // A REPORT command completes on this cycle; the TX side reacts to it
  // directly when idle so the header goes out without an extra cycle.
  logic w_report_cmd;
  // The transmitter may accept a byte: not in the post-strobe blind cycle
  // (tx_busy_i may not yet reflect our strobe) and not busy.
  logic w_tx_ready;

  assign w_report_cmd = new_rx_data_i && (r_rx_state == R_CMD) && (rx_data_i == CMD_REPORT);
  assign w_tx_ready   = !r_tx_hold && !tx_busy_i;

  // RX frame parser: header/command decode, payload streaming, checksum and timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_state <= R_HDR;
      r_rx_cnt   <= '0;
      r_to_cnt   <= '0;
      r_rx_byte  <= '0;
      r_shift_in <= 1'b0;
      r_ready    <= 1'b0;
      r_rx_err   <= 1'b0;
`ifdef SERIAL_CHECKSUM_EN
      r_rx_sum   <= '0;
`endif
    end else begin
      r_shift_in <= 1'b0;
      r_ready    <= 1'b0;
      r_rx_err   <= 1'b0;
      if (new_rx_data_i) begin
        r_to_cnt <= '0;
        case (r_rx_state)
          R_HDR: begin
            // Anything other than HEADER is line noise between frames.
            if (rx_data_i == HEADER) r_rx_state <= R_CMD;
          end
          R_CMD: begin
            if (rx_data_i == CMD_LOAD) begin
              r_rx_state <= R_DATA;
              r_rx_cnt   <= '0;
`ifdef SERIAL_CHECKSUM_EN
              r_rx_sum   <= '0;
`endif
            end else if (rx_data_i == CMD_REPORT) begin
              // Pending-report bookkeeping lives on the TX side.
              r_rx_state <= R_HDR;
            end else begin
              r_rx_err   <= 1'b1;
              r_rx_state <= R_HDR;
            end
          end
          R_DATA: begin
            // Bytes are forwarded immediately; on a later error the host resends.
            r_rx_byte  <= rx_data_i;
            r_shift_in <= 1'b1;
            r_rx_cnt   <= r_rx_cnt + 8'd1;
`ifdef SERIAL_CHECKSUM_EN
            r_rx_sum   <= r_rx_sum ^ rx_data_i;
`endif
            if (r_rx_cnt == LP_NONCE_LAST) begin
`ifdef SERIAL_CHECKSUM_EN
              r_rx_state <= R_SUM;
`else
              r_ready    <= 1'b1;
              r_rx_state <= R_HDR;
`endif
            end
          end
`ifdef SERIAL_CHECKSUM_EN
          R_SUM: begin
            if (rx_data_i == r_rx_sum) r_ready  <= 1'b1;
            else                       r_rx_err <= 1'b1;
            r_rx_state <= R_HDR;
          end
`endif
          default: r_rx_state <= R_HDR;
        endcase
      end else if (r_rx_state != R_HDR) begin
        // Mid-frame silence: abandon the frame once the idle budget is spent.
        if (r_to_cnt == LP_TO_LAST) begin
          r_rx_err   <= 1'b1;
          r_rx_state <= R_HDR;
          r_to_cnt   <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // TX frame generator: report queuing, byte pacing against tx_busy_i, RAM walk.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= T_IDLE;
      r_pending  <= 1'b0;
      r_status   <= '0;
      r_addr     <= '0;
      r_tx_data  <= '0;
      r_new_tx   <= 1'b0;
      r_tx_hold  <= 1'b0;
      r_rbest    <= 1'b0;
`ifdef SERIAL_CHECKSUM_EN
      r_tx_sum   <= '0;
`endif
    end else begin
      r_new_tx  <= 1'b0;
      r_tx_hold <= 1'b0;
      r_rbest   <= 1'b0;

      // Any REPORT seen while a frame is in flight leaves exactly one frame
      // queued; further REPORTs simply re-set the same flag.
      if (r_tx_state != T_IDLE && w_report_cmd) r_pending <= 1'b1;

      case (r_tx_state)
        T_IDLE: begin
          if (r_pending || w_report_cmd) begin
            r_pending  <= 1'b0;
            r_status   <= status_i;
            r_addr     <= '0;
            r_tx_state <= T_HDR;
          end
        end
        T_HDR: begin
          if (w_tx_ready) begin
            r_tx_data  <= HEADER;
            r_new_tx   <= 1'b1;
            r_tx_hold  <= 1'b1;
`ifdef SERIAL_CHECKSUM_EN
            r_tx_sum   <= HEADER;
`endif
            r_tx_state <= T_STAT;
          end
        end
        T_STAT: begin
          if (w_tx_ready) begin
            r_tx_data  <= r_status;
            r_new_tx   <= 1'b1;
            r_tx_hold  <= 1'b1;
`ifdef SERIAL_CHECKSUM_EN
            r_tx_sum   <= r_tx_sum ^ r_status;
`endif
            r_tx_state <= T_DATA;
          end
        end
        T_DATA: begin
          // r_addr has been stable for at least one cycle here, so ram_data_i
          // holds the byte at r_addr.
          if (w_tx_ready) begin
            r_tx_data <= ram_data_i;
            r_new_tx  <= 1'b1;
            r_tx_hold <= 1'b1;
`ifdef SERIAL_CHECKSUM_EN
            r_tx_sum  <= r_tx_sum ^ ram_data_i;
`endif
            if (r_addr == LP_ADDR_LAST) begin
              r_addr <= '0;
`ifdef SERIAL_CHECKSUM_EN
              r_tx_state <= T_SUM;
`else
              r_tx_state <= T_DONE;
`endif
            end else begin
              r_addr <= r_addr + RAM_AW'(1);
            end
          end
        end
`ifdef SERIAL_CHECKSUM_EN
        T_SUM: begin
          if (w_tx_ready) begin
            r_tx_data  <= r_tx_sum;
            r_new_tx   <= 1'b1;
            r_tx_hold  <= 1'b1;
            r_tx_state <= T_DONE;
          end
        end
`endif
        T_DONE: begin
          r_rbest    <= 1'b1;
          r_tx_state <= T_IDLE;
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  assign ram_address_o             = r_addr;
  assign tx_data_o                 = r_tx_data;
  assign new_tx_data_o             = r_new_tx;
  assign rx_byte_o                 = r_rx_byte;
  assign shift_in_o                = r_shift_in;
  assign ready_o                   = r_ready;
  assign reset_best_nonce_module_o = r_rbest;
  assign rx_error_o                = r_rx_err;

endmodule

// File: tb/tb_serial_link.sv
// Testbench for serial_link: scoreboard of expected nonce-shift bytes and
// expected TX frame bytes, filled when stimulus is driven and drained by a
// negedge monitor. Works with or without SERIAL_CHECKSUM_EN.
`timescale 1ns/1ps

module tb_serial_link;

  localparam int NB = 4;
  localparam int RB = 4;
  localparam int AW = 5;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data = 8'h00;
  logic [7:0]    tx_data;
  logic          new_tx_data;
  logic          tx_busy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          new_rx_data = 1'b0;
  logic [7:0]    status = 8'h3C;
  logic [7:0]    rx_byte;
  logic          shift_in;
  logic          ready;
  logic          rbest;
  logic          rx_err;

  logic [7:0] ram_mem [0:(1<<AW)-1];
  logic [7:0] exp_tx_q [$];
  logic [7:0] exp_sh_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_ready = 0;
  int n_err   = 0;
  int n_rbest = 0;
  int n_txb   = 0;

  always #5 clk = ~clk;

  serial_link #(
    .HEADER(8'hA5), .NONCE_BYTES(NB), .RESULT_BYTES(RB), .RAM_AW(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ram_address_o(ram_address), .ram_data_i(ram_data),
    .tx_data_o(tx_data), .new_tx_data_o(new_tx_data), .tx_busy_i(tx_busy),
    .rx_data_i(rx_data), .new_rx_data_i(new_rx_data), .status_i(status),
    .rx_byte_o(rx_byte), .shift_in_o(shift_in), .ready_o(ready),
    .reset_best_nonce_module_o(rbest), .rx_error_o(rx_err)
  );

  // Synchronous-read RAM: data valid one cycle after the address.
  always @(posedge clk) ram_data <= ram_mem[ram_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy for 3 cycles after each strobe.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (new_tx_data) begin
        tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Output monitor / scoreboard drain.
  initial begin
    forever begin
      @(negedge clk);
      if (shift_in) begin
        if (exp_sh_q.size() == 0) chk("shift_unexpected", 1, 0);
        else chk("shift_byte", rx_byte, exp_sh_q.pop_front());
      end
      if (new_tx_data) begin
        n_txb++;
        if (exp_tx_q.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'h1FF);
        else chk("tx_byte", tx_data, exp_tx_q.pop_front());
      end
      if (ready)  n_ready++;
      if (rx_err) n_err++;
      if (rbest)  n_rbest++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rx_send(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
  endtask

  // LOAD frame; payload packed MSB-first. Returns at the negedge where the
  // response to the final byte is visible.
  task automatic load(input logic [31:0] payload, input logic [7:0] sum);
    logic [7:0] b;
    rx_send(8'hA5);
    rx_send(8'h01);
    for (int i = 0; i < NB; i++) begin
      b = payload[8*(NB-1-i) +: 8];
      exp_sh_q.push_back(b);
      rx_send(b);
      chk("shift_latency", shift_in, 1);
    end
`ifdef SERIAL_CHECKSUM_EN
    rx_send(sum);
`else
    if (sum == 8'h00) b = 8'h00;  // checksum byte not sent in this build
`endif
  endtask

  task automatic push_frame(input logic [7:0] st);
    logic [7:0] s;
    exp_tx_q.push_back(8'hA5);
    exp_tx_q.push_back(st);
    s = 8'hA5 ^ st;
    for (int i = 0; i < RB; i++) begin
      exp_tx_q.push_back(8'(i));
      s = s ^ 8'(i);
    end
`ifdef SERIAL_CHECKSUM_EN
    exp_tx_q.push_back(s);
`endif
  endtask

  task automatic wait_rbest(input int target, input int bound, input string tag);
    int n;
    n = 0;
    while (n_rbest < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n_rbest >= target), 1);
  endtask

  initial begin
    int r0, e0, b0, t0, n;
    for (int i = 0; i < (1 << AW); i++) ram_mem[i] = 8'(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_new_tx", new_tx_data, 0);
    chk("rst_shift", shift_in, 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_rbest", rbest, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_byte", rx_byte, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good LOAD
    r0 = n_ready; e0 = n_err;
    load(32'h01020304, 8'h04);
    chk("load_ready", ready, 1);
    chk("load_no_err", rx_err, 0);
    repeat (3) @(negedge clk);
    chk("load_ready_cnt", n_ready - r0, 1);
    chk("load_err_cnt", n_err - e0, 0);
    chk("load_shift_q", exp_sh_q.size(), 0);

`ifdef SERIAL_CHECKSUM_EN
    // Bad checksum
    r0 = n_ready; e0 = n_err;
    load(32'h01020304, 8'h05);
    chk("badsum_err", rx_err, 1);
    chk("badsum_ready", ready, 0);
    repeat (3) @(negedge clk);
    chk("badsum_ready_cnt", n_ready - r0, 0);
    chk("badsum_err_cnt", n_err - e0, 1);
`endif

    // Noise byte dropped, bad command flagged, next LOAD accepted
    e0 = n_err;
    rx_send(8'h33);
    chk("noise_no_err", rx_err, 0);
    rx_send(8'hA5);
    rx_send(8'h7F);
    chk("badcmd_err", rx_err, 1);
    r0 = n_ready;
    load(32'h10203040, 8'h40);
    chk("after_badcmd_ready", ready, 1);
    repeat (3) @(negedge clk);
    chk("badcmd_err_cnt", n_err - e0, 1);
    chk("after_badcmd_ready_cnt", n_ready - r0, 1);

    // Single REPORT, status latched at start
    status = 8'h3C;
    push_frame(8'h3C);
    b0 = n_rbest;
    rx_send(8'hA5);
    rx_send(8'h02);
    status = 8'hFF;
    n = 0;
    while (!new_tx_data && n < 3) begin
      @(negedge clk);
      n++;
    end
    chk("report_latency_ok", (n <= 2), 1);
    wait_rbest(b0 + 1, 300, "report_done");
    repeat (5) @(negedge clk);
    chk("report_q_empty", exp_tx_q.size(), 0);
    chk("report_rbest_cnt", n_rbest - b0, 1);
    chk("report_addr_wrap", ram_address, 0);
    status = 8'h3C;

    // Three REPORTs during one frame -> two frames
    push_frame(8'h3C);
    push_frame(8'h3C);
    b0 = n_rbest; t0 = n_txb;
    rx_send(8'hA5);
    rx_send(8'h02);
    n = 0;
    while (n_txb == t0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("multi_started", (n_txb > t0), 1);
    rx_send(8'hA5);
    rx_send(8'h02);
    rx_send(8'hA5);
    rx_send(8'h02);
    wait_rbest(b0 + 2, 600, "multi_done");
    repeat (60) @(negedge clk);
    chk("multi_rbest_cnt", n_rbest - b0, 2);
    chk("multi_q_empty", exp_tx_q.size(), 0);

    // Inter-byte timeout mid-LOAD, then recovery
    e0 = n_err;
    rx_send(8'hA5);
    rx_send(8'h01);
    exp_sh_q.push_back(8'h11);
    rx_send(8'h11);
    exp_sh_q.push_back(8'h22);
    rx_send(8'h22);
    n = 0;
    while (!rx_err && n < TO + 5) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_err", rx_err, 1);
    chk("timeout_window", (n >= TO - 1 && n <= TO + 1), 1);
    chk("timeout_shift_q", exp_sh_q.size(), 0);
    r0 = n_ready;
    load(32'hAABBCCDD, 8'h00);
    repeat (3) @(negedge clk);
    chk("timeout_recover_ready", n_ready - r0, 1);
    chk("timeout_err_cnt", n_err - e0, 1);

    // Reset in the middle of a transmission
    push_frame(8'h3C);
    t0 = n_txb;
    rx_send(8'hA5);
    rx_send(8'h02);
    n = 0;
    while (n_txb == t0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_tx_started", (n_txb > t0), 1);
    @(negedge clk);
    exp_tx_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t0 = n_txb; b0 = n_rbest;
    repeat (40) @(negedge clk);
    chk("rst_tx_quiet", n_txb - t0, 0);
    chk("rst_no_rbest", n_rbest - b0, 0);
    chk("rst_new_tx_low", new_tx_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
